// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: Set-2 prefix bytes, frame/decoder state types and the
// buffered key-event record.
package ps2_pkg;

    localparam logic [7:0]  CODE_E0    = 8'hE0;
    localparam logic [7:0]  CODE_F0    = 8'hF0;
    localparam logic [7:0]  CODE_E1    = 8'hE1;
    localparam logic [7:0]  PAUSE_CODE = 8'h77;
    localparam int unsigned PAUSE_SKIP = 7;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    typedef enum logic {
        DecNorm,
        DecPause
    } dec_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // 0x00 / 0xFF are keyboard error/overrun fillers, never real keys.
    function automatic logic is_filler(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/hex.sv
// Hex digit to 7-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module hex (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchroniser, ps2_clk glitch filter, 11-bit frame FSM and timeout.
// Define PS2_PARITY_EN to reject bytes with bad odd parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       parity_err
);

`ifdef PS2_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    localparam int unsigned FiltW = $clog2(FILT_CYCLES + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_s, data_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fall_q, fall_d;

    // Filtered clock flips only after FILT_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltW'(FILT_CYCLES - 1)) begin
                filt_d = clk_s;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    frame_state_e    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;
    logic            parity_bad;

    assign parity_bad = ParityEn && !(^{shift_q, par_q});

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = '0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (state_q != StIdle) begin
            tmo_d = tmo_q + TmoW'(1);
        end
        if (fall_q) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_s;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (parity_bad) begin
                        parity_err_d = 1'b1;
                    end else begin
                        byte_valid_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = StIdle;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: rtl/ps2_keyrx.sv
// PS/2 keyboard receiver top: Set-2 prefix decoder, show-ahead event FIFO and 4-digit display.
// PS2_PARITY_EN (seen by ps2_frame_rx) enables odd-parity checking.
module ps2_keyrx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    input  logic                              rd_en,
    input  logic                              ovf_clr,
    output logic                              event_valid,
    output logic [7:0]                        event_code,
    output logic                              event_ext,
    output logic                              event_brk,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic [6:0]                        out0,
    output logic [6:0]                        out1,
    output logic [6:0]                        out2,
    output logic [6:0]                        out3
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILT_CYCLES   (FILT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    dec_state_e dec_q, dec_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       ev_valid_q, ev_valid_d;
    ps2_event_t ev_q, ev_d;

    always_comb begin
        dec_d      = dec_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        ev_valid_d = 1'b0;
        ev_d       = ev_q;
        if (parity_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            unique case (dec_q)
                DecNorm: begin
                    if (rx_byte == CODE_E0) begin
                        ext_d = 1'b1;
                    end else if (rx_byte == CODE_F0) begin
                        brk_d = 1'b1;
                    end else if (rx_byte == CODE_E1) begin
                        ext_d  = 1'b1;
                        dec_d  = DecPause;
                        skip_d = '0;
                    end else begin
                        if (!is_filler(rx_byte)) begin
                            ev_valid_d = 1'b1;
                            ev_d       = {ext_q, brk_q, rx_byte};
                        end
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                DecPause: begin
                    // The Pause make sequence carries no release, so it collapses to one event.
                    if (skip_q == 3'(PAUSE_SKIP - 1)) begin
                        ev_valid_d = 1'b1;
                        ev_d       = {1'b1, 1'b0, PAUSE_CODE};
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                        dec_d      = DecNorm;
                    end else begin
                        skip_d = skip_q + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q      <= DecNorm;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
        end else begin
            dec_q      <= dec_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            ev_valid_q <= ev_valid_d;
            ev_q       <= ev_d;
        end
    end

    ps2_event_t      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;
    logic            empty, full, pop, push, drop;
    ps2_event_t      head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign pop   = rd_en && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push  = ev_valid_q && (!full || pop);
    assign drop  = ev_valid_q && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ev_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign event_valid = !empty;
    assign event_code  = empty ? 8'h00 : head.code;
    assign event_ext   = !empty && head.ext;
    assign event_brk   = !empty && head.brk;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;

    ps2_event_t disp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (ev_valid_q) begin
            disp_q <= ev_q;
        end
    end

    hex u_hex0 (
        .digit(disp_q.code[3:0]),
        .seg  (out0)
    );

    hex u_hex1 (
        .digit(disp_q.code[7:4]),
        .seg  (out1)
    );

    hex u_hex2 (
        .digit(disp_q.ext ? 4'hE : 4'h0),
        .seg  (out2)
    );

    hex u_hex3 (
        .digit(disp_q.brk ? 4'hF : 4'h0),
        .seg  (out3)
    );

endmodule

// File: tb/tb_ps2_keyrx.sv
// Scoreboard bench for ps2_keyrx: bit-banged PS/2 frames, expected events queued at send time.
module tb_ps2_keyrx;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned FILT_CYCLES    = 4;
    localparam int unsigned TIMEOUT_CYCLES = 1000;
    localparam int unsigned FIFO_DEPTH     = 8;
    localparam int          LATENCY        = SYNC_STAGES + FILT_CYCLES + 3;
    localparam int          HALF           = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en    = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic       event_valid, event_ext, event_brk, overflow, frame_err, parity_err;
    logic [7:0] event_code;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
    logic [6:0] out0, out1, out2, out3;

    int         n_cmp    = 0;
    int         n_err    = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic [9:0] exp_q[$];

    ps2_keyrx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILT_CYCLES   (FILT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .ovf_clr    (ovf_clr),
        .event_valid(event_valid),
        .event_code (event_code),
        .event_ext  (event_ext),
        .event_brk  (event_brk),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = 1'b1;
        return f;
    endfunction

    // Drives the first nbits of a frame; reports the cycle (after the last falling edge)
    // at which fifo_count moved, and can hold rd_en for posedge number pop_at.
    task automatic send_frame(input logic [10:0] f, input int nbits, input int pop_at,
                              output int lat);
        int prev;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            prev = int'(fifo_count);
            for (int c = 1; c <= HALF; c++) begin
                @(posedge clk);
                #1;
                if (i == nbits - 1 && lat == 0 && int'(fifo_count) != prev) lat = c;
                rd_en = (i == nbits - 1 && c == pop_at - 1);
            end
            @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int lat;
        send_frame(mk_frame(b, 1'b0), 11, 0, lat);
    endtask

    task automatic read_event(output logic [9:0] ev, output bit ok);
        ok = 1'b0;
        ev = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (event_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            ev    = {event_ext, event_brk, event_code};
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({event_valid, event_code, event_ext, event_brk, fifo_count, overflow, frame_err,
             parity_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b code=%h ext=%b brk=%b cnt=%0d ovf=%b fe=%b pe=%b, want all 0",
                     event_valid, event_code, event_ext, event_brk, fifo_count, overflow,
                     frame_err, parity_err);
        end
        n_cmp++;
        if ({out3, out2, out1, out0} !== {4{seg7(4'h0)}}) begin
            n_err++;
            $display("FAIL reset_display: got %h %h %h %h, want %h each", out3, out2, out1, out0,
                     seg7(4'h0));
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make_break();
        int lat;
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(mk_frame(8'h1C, 1'b0), 11, 0, lat);
        n_cmp++;
        if (lat !== LATENCY) begin
            n_err++;
            $display("FAIL make_latency: got %0d cycles, want %0d", lat, LATENCY);
        end
        exp_q.push_back({2'b01, 8'h1C});
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++;
        if ({out3, out1, out0} !== {seg7(4'hF), seg7(4'h1), seg7(4'hC)}) begin
            n_err++;
            $display("FAIL break_display: got out3=%h out1=%h out0=%h, want %h %h %h",
                     out3, out1, out0, seg7(4'hF), seg7(4'h1), seg7(4'hC));
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL make_break_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
    endtask

    task automatic test_extended();
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b10, 8'h75});
        send_byte(8'hE0);
        send_byte(8'h75);
        exp_q.push_back({2'b11, 8'h75});
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_cmp++;
        if ({out3, out2, out1, out0} !== {seg7(4'hF), seg7(4'hE), seg7(4'h7), seg7(4'h5)}) begin
            n_err++;
            $display("FAIL ext_display: got %h %h %h %h, want %h %h %h %h", out3, out2, out1,
                     out0, seg7(4'hF), seg7(4'hE), seg7(4'h7), seg7(4'h5));
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL ext_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        logic [9:0] got, exp;
        bit ok;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        exp_q.push_back({2'b10, 8'h77});
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        n_cmp++;
        if (fifo_count !== 1) begin
            n_err++;
            $display("FAIL pause_count: got %0d events, want 1", fifo_count);
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL pause_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (event_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pause_empty: event_valid=%b, want 0", event_valid);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [7:0] code;
        logic [9:0] got, exp;
        bit ok;
        for (int i = 0; i < 9; i++) begin
            code = 8'h10 + 8'(i);
            if (i < FIFO_DEPTH) exp_q.push_back({2'b00, code});
            send_byte(code);
        end
        n_cmp++;
        if (fifo_count !== FIFO_DEPTH || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_full: count=%0d ovf=%b, want %0d and 1", fifo_count, overflow,
                     FIFO_DEPTH);
        end
        n_cmp++;
        if ({out1, out0} !== {seg7(4'h1), seg7(4'h8)}) begin
            n_err++;
            $display("FAIL ovf_display: got %h %h, want %h %h", out1, out0, seg7(4'h1), seg7(4'h8));
        end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: overflow=%b, want 0", overflow);
        end
        void'(exp_q.pop_front());
        exp_q.push_back({2'b00, 8'h19});
        send_frame(mk_frame(8'h19, 1'b0), 11, LATENCY, lat);
        n_cmp++;
        if (fifo_count !== FIFO_DEPTH || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_push_pop: count=%0d ovf=%b, want %0d and 0", fifo_count, overflow,
                     FIFO_DEPTH);
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL ovf_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
    endtask

    task automatic test_parity();
        int lat, p0;
        logic [9:0] got, exp;
        bit ok;
        p0 = perr_cnt;
`ifndef PS2_PARITY_EN
        exp_q.push_back({2'b00, 8'h1C});
`endif
        send_frame(mk_frame(8'h1C, 1'b1), 11, 0, lat);
        n_cmp++;
`ifdef PS2_PARITY_EN
        if (perr_cnt - p0 !== 1 || fifo_count !== 0) begin
            n_err++;
            $display("FAIL parity_reject: pulses=%0d count=%0d, want 1 and 0", perr_cnt - p0,
                     fifo_count);
        end
`else
        if (perr_cnt - p0 !== 0 || fifo_count !== 1) begin
            n_err++;
            $display("FAIL parity_ignore: pulses=%0d count=%0d, want 0 and 1", perr_cnt - p0,
                     fifo_count);
        end
`endif
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL parity_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
    endtask

    task automatic test_timeout();
        int lat, f0;
        logic [9:0] got, exp;
        bit ok;
        n_cmp++;
        if (ferr_cnt !== 0) begin
            n_err++;
            $display("FAIL no_spurious_frame_err: got %0d pulses, want 0", ferr_cnt);
        end
        f0 = ferr_cnt;
        send_frame(mk_frame(8'h29, 1'b0), 5, 0, lat);
        repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
        n_cmp++;
        if (ferr_cnt - f0 !== 1 || fifo_count !== 0) begin
            n_err++;
            $display("FAIL timeout: pulses=%0d count=%0d, want 1 and 0", ferr_cnt - f0, fifo_count);
        end
        exp_q.push_back({2'b00, 8'h29});
        send_byte(8'h29);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL after_timeout_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        logic [9:0] got, exp;
        bit ok;
        send_byte(8'h1C);
        send_byte(8'hE1);
        send_byte(8'h14);
        send_frame(mk_frame(8'h77, 1'b0), 5, 0, lat);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({event_valid, event_code, event_ext, event_brk, fifo_count, overflow, frame_err,
             parity_err} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: valid=%b code=%h cnt=%0d ovf=%b, want all 0",
                     event_valid, event_code, fifo_count, overflow);
        end
        n_cmp++;
        if ({out3, out2, out1, out0} !== {4{seg7(4'h0)}}) begin
            n_err++;
            $display("FAIL midreset_display: got %h %h %h %h, want %h each", out3, out2, out1,
                     out0, seg7(4'h0));
        end
        exp_q.delete();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back({2'b00, 8'h1C});
        send_byte(8'h1C);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_event(got, ok);
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL post_reset_event: got %h (present=%0d), want %h", got, ok, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_overflow();
        test_parity();
        test_timeout();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_keyrx.md
# ps2_keyrx

Parametrised PS/2 keyboard receiver and scan-code decoder, the successor to the single-byte display receiver. It works fully in the `clk` domain: it oversamples `ps2_clk`, frames 11-bit packets, checks them, decodes Set-2 prefixes (E0/F0/E1) into key events, and buffers the events in a FIFO for a host consumer. It also drives four 7-segment digits with the most recent event, for the board display.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `ps2_clk`/`ps2_data` (≥2).
- `FILT_CYCLES`, 4: consecutive stable samples before filtered `ps2_clk` changes (≥1).
- `TIMEOUT_CYCLES`, 50000: max `clk` cycles between falling edges inside a frame.
- `FIFO_DEPTH`, 8: event FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw keyboard clock, asynchronous.
- `ps2_data`  in  1  raw keyboard data, asynchronous.
- `rd_en`  in  1  pop FIFO head.
- `ovf_clr`  in  1  clear sticky `overflow`.
- `event_valid`  out  1  FIFO non-empty.
- `event_code`  out  8  head key code.
- `event_ext`  out  1  head was E0/E1-prefixed.
- `event_brk`  out  1  head is a release (F0-prefixed).
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  occupancy.
- `overflow`  out  1  sticky, event dropped on full.
- `frame_err`  out  1  1-cycle pulse: bad stop bit or timeout.
- `parity_err`  out  1  1-cycle pulse: odd-parity failure.
- `out0`..`out3`  out  7 each  hex digits, same segment encoding as the existing `hex` module.

## Operation
- Input path: `SYNC_STAGES` synchroniser, then a filter on `ps2_clk`. The filtered clock toggles only after `FILT_CYCLES` identical synchronised samples. A falling edge of the filtered clock produces a 1-cycle `fall` strobe, and `ps2_data` (synchronised) is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 bits, LSB first, then go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: data=1 → byte accepted. Data=0 → `frame_err` pulse, byte discarded. Either way, return to IDLE.
- Timeout: in any state other than IDLE, if `TIMEOUT_CYCLES` pass without `fall`, the FSM goes to IDLE and pulses `frame_err`.
- Decoder, on each accepted byte:
  - E0: set `ext`.
  - F0: set `brk`.
  - E1: set `ext`, enter PAUSE and swallow the next 7 bytes, then emit {0x77, ext=1, brk=0}.
  - 0x00 or 0xFF: dropped, flags cleared.
  - Any other byte: emit {byte, ext, brk}, then clear both flags.
- FIFO, show-ahead:
  - Head is presented whenever `event_valid`=1.
  - `rd_en` while empty is ignored.
  - A push while full drops the event and sets `overflow`. If a pop happens in the same cycle, the push succeeds and there is no overflow.
  - `ovf_clr` clears `overflow`. If a new drop occurs in the same cycle, `overflow` is set.
- Display, updated on every emitted event, including dropped ones:
  - `out1:out0` = code.
  - `out2` = E if ext, else 0.
  - `out3` = F if brk, else 0.

## Timing
- Reset values:
  - All FSMs in IDLE; flags 0; FIFO empty; `fifo_count`=0.
  - `event_valid`, `event_code`, `event_ext`, `event_brk`, `overflow`, `frame_err`, `parity_err` all 0.
  - `out0`..`out3` show "0".
- Latency: `event_valid` rises exactly SYNC_STAGES+FILT_CYCLES+3 `clk` cycles after the raw stop-bit falling edge, given clean input. The display updates in the same cycle.
- A pop takes effect on the clock edge where `rd_en`=1. The next head is visible on the following cycle.
- Reset asserted mid-frame or mid-PAUSE: all state is discarded immediately and no event is emitted.

## Configuration
- `PS2_PARITY_EN` defined:
  - Odd parity is checked.
  - On a failure, `parity_err` pulses in the STOP cycle, the byte is discarded, and the decoder flags are cleared.
- `PS2_PARITY_EN` undefined: the parity bit is sampled and ignored, and `parity_err` is tied to 0.

## Structure
- Shared package `ps2_pkg`: the prefix constants (E0, F0, E1, PAUSE_CODE 0x77, PAUSE_SKIP 7), the frame-state typedef, and the 10-bit event typedef {ext, brk, code}.
- Sub-module `ps2_frame_rx`: synchroniser, filter, frame FSM and timeout. It outputs byte, byte_valid, frame_err and parity_err.
- Decoder, FIFO and display stay in the top level, which reuses the existing `hex` module four times.

## Test plan
- Frame 0x1C, then F0 1C; read both events → {1C,0,0} then {1C,0,1}; `out1:out0`=1C, `out3`=F.
- E0 75, then E0 F0 75 → {75,1,0} then {75,1,1}.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event, {77,1,0}.
- 9 events without reads (FIFO_DEPTH=8) → `fifo_count`=8, `overflow`=1. Then a push and a pop in the same cycle while full → count stays 8, no new drop. `ovf_clr` → `overflow`=0.
- Bad parity on 0x1C (macro on) → `parity_err` pulse, no event. Same stimulus with the macro off → event {1C,0,0}.
- Stop after 4 data bits for TIMEOUT_CYCLES → `frame_err` pulse. Next clean frame 0x29 → {29,0,0}. Assert `rst_n` mid-frame → all outputs return to reset values.
